// File: rtl/alu_if.sv
// Control and flag bundle between the control unit and the ALU.
// The control unit is the master; the ALU is the slave.
interface alu_if;
    logic       alu_a_load;
    logic       alu_b_load;
    logic [4:0] alu_op;
    logic       alu_execute;
    logic       alu_out_en;
    logic       alu_zero;
    logic       alu_lt;
    logic       alu_ltu;

    modport master (
        output alu_a_load,
        output alu_b_load,
        output alu_op,
        output alu_execute,
        output alu_out_en,
        input  alu_zero,
        input  alu_lt,
        input  alu_ltu
    );

    modport slave (
        input  alu_a_load,
        input  alu_b_load,
        input  alu_op,
        input  alu_execute,
        input  alu_out_en,
        output alu_zero,
        output alu_lt,
        output alu_ltu
    );
endinterface

// File: rtl/alu.sv
// RV32IM ALU with operand and result registers on the shared tri-state bus.
// Multiply and divide are single-cycle combinational paths.
module alu (
    input  logic        clock,
    input  logic        reset,
    inout  wire  [31:0] bus,
    alu_if.slave        ctl
);
    typedef enum logic [4:0] {
        OP_ADD    = 5'd0,
        OP_SUB    = 5'd1,
        OP_SLL    = 5'd2,
        OP_SLT    = 5'd3,
        OP_SLTU   = 5'd4,
        OP_XOR    = 5'd5,
        OP_SRL    = 5'd6,
        OP_SRA    = 5'd7,
        OP_OR     = 5'd8,
        OP_AND    = 5'd9,
        OP_MUL    = 5'd10,
        OP_MULH   = 5'd11,
        OP_MULHSU = 5'd12,
        OP_MULHU  = 5'd13,
        OP_DIV    = 5'd14,
        OP_DIVU   = 5'd15,
        OP_REM    = 5'd16,
        OP_REMU   = 5'd17,
        OP_PASS_B = 5'd18
    } op_e;

    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic [31:0] res;
    op_e         op;

    assign op = op_e'(ctl.alu_op);

    // One 33x33 multiplier; the extra bit carries sign or zero per operand.
    logic        ma_sgn;
    logic        mb_sgn;
    logic [32:0] ma;
    logic [32:0] mb;
    logic [63:0] prod;

    assign ma_sgn = (op == OP_MULH) || (op == OP_MULHSU);
    assign mb_sgn = (op == OP_MULH);
    assign ma     = {ma_sgn & a[31], a};
    assign mb     = {mb_sgn & b[31], b};
    assign prod   = {{31{ma[32]}}, ma} * {{31{mb[32]}}, mb};

    // Signed divide runs on magnitudes, then fixes signs afterwards.
    // The overflow case falls out naturally: -(0x80000000) wraps to itself.
    logic        div_sgn;
    logic        a_neg;
    logic        b_neg;
    logic        b_zero;
    logic [31:0] ua;
    logic [31:0] ub;
    logic [31:0] dsr;
    logic [31:0] uq;
    logic [31:0] ur;
    logic [31:0] quo;
    logic [31:0] rem;

    assign div_sgn = (op == OP_DIV) || (op == OP_REM);
    assign a_neg   = div_sgn & a[31];
    assign b_neg   = div_sgn & b[31];
    assign b_zero  = (b == 32'd0);
    assign ua      = a_neg ? (32'd0 - a) : a;
    assign ub      = b_neg ? (32'd0 - b) : b;
    assign dsr     = b_zero ? 32'd1 : ub;
    assign uq      = ua / dsr;
    assign ur      = ua % dsr;
    assign quo     = b_zero ? 32'hFFFF_FFFF
                            : ((a_neg ^ b_neg) ? (32'd0 - uq) : uq);
    assign rem     = b_zero ? a : (a_neg ? (32'd0 - ur) : ur);

    // Result select; unused codes produce zero.
    always_comb begin
        res = 32'd0;
        unique case (op)
            OP_ADD:    res = a + b;
            OP_SUB:    res = a - b;
            OP_SLL:    res = a << b[4:0];
            OP_SLT:    res = {31'd0, $signed(a) < $signed(b)};
            OP_SLTU:   res = {31'd0, a < b};
            OP_XOR:    res = a ^ b;
            OP_SRL:    res = a >> b[4:0];
            OP_SRA:    res = $signed(a) >>> b[4:0];
            OP_OR:     res = a | b;
            OP_AND:    res = a & b;
            OP_MUL:    res = prod[31:0];
            OP_MULH:   res = prod[63:32];
            OP_MULHSU: res = prod[63:32];
            OP_MULHU:  res = prod[63:32];
            OP_DIV:    res = quo;
            OP_DIVU:   res = quo;
            OP_REM:    res = rem;
            OP_REMU:   res = rem;
            OP_PASS_B: res = b;
            default:   res = 32'd0;
        endcase
    end

    // Operand and result registers; execute uses pre-edge A and B.
    always_ff @(posedge clock) begin
        if (reset) begin
            a <= 32'd0;
            b <= 32'd0;
            r <= 32'd0;
        end else begin
            if (ctl.alu_a_load)  a <= bus;
            if (ctl.alu_b_load)  b <= bus;
            if (ctl.alu_execute) r <= res;
        end
    end

    assign ctl.alu_zero = (r == 32'd0);
    assign ctl.alu_lt   = $signed(a) < $signed(b);
    assign ctl.alu_ltu  = a < b;

    assign bus = (ctl.alu_out_en && !reset) ? r : 32'hzzzz_zzzz;
endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for the RV32IM ALU.
// Each task drives one scenario and checks its own results.
module tb_alu;
    localparam logic [4:0] ADD    = 5'd0;
    localparam logic [4:0] SUB    = 5'd1;
    localparam logic [4:0] SLL    = 5'd2;
    localparam logic [4:0] SLT    = 5'd3;
    localparam logic [4:0] SLTU   = 5'd4;
    localparam logic [4:0] XORO   = 5'd5;
    localparam logic [4:0] SRL    = 5'd6;
    localparam logic [4:0] SRA    = 5'd7;
    localparam logic [4:0] ORO    = 5'd8;
    localparam logic [4:0] ANDO   = 5'd9;
    localparam logic [4:0] MUL    = 5'd10;
    localparam logic [4:0] MULH   = 5'd11;
    localparam logic [4:0] MULHSU = 5'd12;
    localparam logic [4:0] MULHU  = 5'd13;
    localparam logic [4:0] DIV    = 5'd14;
    localparam logic [4:0] DIVU   = 5'd15;
    localparam logic [4:0] REM    = 5'd16;
    localparam logic [4:0] REMU   = 5'd17;
    localparam logic [4:0] PASSB  = 5'd18;
    localparam logic [31:0] PAT   = 32'h1234_5678;

    logic        clock = 1'b0;
    logic        reset;
    wire  [31:0] bus;
    logic [31:0] drv;
    logic        drv_en;
    int          n_checks = 0;
    int          n_fail = 0;

    alu_if ifc ();

    assign bus = drv_en ? drv : 32'hzzzz_zzzz;

    alu dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus),
        .ctl   (ifc)
    );

    always #5 clock = ~clock;

    task automatic cycle();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic idle();
        ifc.alu_a_load  = 1'b0;
        ifc.alu_b_load  = 1'b0;
        ifc.alu_execute = 1'b0;
        ifc.alu_out_en  = 1'b0;
        ifc.alu_op      = 5'd0;
        drv_en          = 1'b0;
        drv             = 32'd0;
    endtask

    task automatic load_a(input logic [31:0] v);
        drv = v;
        drv_en = 1'b1;
        ifc.alu_a_load = 1'b1;
        cycle();
        ifc.alu_a_load = 1'b0;
        drv_en = 1'b0;
    endtask

    task automatic load_b(input logic [31:0] v);
        drv = v;
        drv_en = 1'b1;
        ifc.alu_b_load = 1'b1;
        cycle();
        ifc.alu_b_load = 1'b0;
        drv_en = 1'b0;
    endtask

    task automatic exec(input logic [4:0] op);
        ifc.alu_op = op;
        ifc.alu_execute = 1'b1;
        cycle();
        ifc.alu_execute = 1'b0;
    endtask

    task automatic read_bus(output logic [31:0] v);
        ifc.alu_out_en = 1'b1;
        #1;
        v = bus;
        ifc.alu_out_en = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        load_a(32'd0);
        load_b(32'd1);
        exec(SUB);
        reset = 1'b1;
        ifc.alu_a_load  = 1'b1;
        ifc.alu_b_load  = 1'b1;
        ifc.alu_execute = 1'b1;
        ifc.alu_out_en  = 1'b1;
        ifc.alu_op      = ADD;
        drv = PAT;
        drv_en = 1'b1;
        #1;
        n_checks++;
        if (bus !== PAT) begin
            n_fail++;
            $display("FAIL reset_bus_release: got %h want %h", bus, PAT);
        end
        cycle();
        cycle();
        n_checks++;
        if (bus !== PAT) begin
            n_fail++;
            $display("FAIL reset_bus_hold: got %h want %h", bus, PAT);
        end
        reset = 1'b0;
        idle();
        #1;
        n_checks++;
        if (ifc.alu_zero !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_zero: got %b want 1", ifc.alu_zero);
        end
        n_checks++;
        if ({ifc.alu_lt, ifc.alu_ltu} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_lt: got %b%b want 00", ifc.alu_lt, ifc.alu_ltu);
        end
        read_bus(v);
        n_checks++;
        if (v !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_r: got %h want 00000000", v);
        end
        exec(SUB);
        read_bus(v);
        n_checks++;
        if (v !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_a_minus_b: got %h want 00000000", v);
        end
        exec(PASSB);
        read_bus(v);
        n_checks++;
        if (v !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_b: got %h want 00000000", v);
        end
    endtask

    task automatic test_add_sub();
        logic [31:0] v;
        load_a(32'hFFFF_FFFF);
        load_b(32'd1);
        exec(ADD);
        read_bus(v);
        n_checks++;
        if (v !== 32'd0) begin
            n_fail++;
            $display("FAIL add_wrap: got %h want 00000000", v);
        end
        n_checks++;
        if (ifc.alu_zero !== 1'b1) begin
            n_fail++;
            $display("FAIL add_zero: got %b want 1", ifc.alu_zero);
        end
        load_a(32'd0);
        exec(SUB);
        read_bus(v);
        n_checks++;
        if (v !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("FAIL sub_wrap: got %h want ffffffff", v);
        end
        n_checks++;
        if (ifc.alu_zero !== 1'b0) begin
            n_fail++;
            $display("FAIL sub_zero: got %b want 0", ifc.alu_zero);
        end
    endtask

    task automatic test_shift_cmp();
        logic [4:0]  ops [4] = '{SRA, SRL, SLL, SLT};
        logic [31:0] exp [4] = '{32'hC000_0000, 32'h4000_0000, 32'd0, 32'd1};
        logic [31:0] v;
        load_a(32'h8000_0000);
        load_b(32'h0000_0021);
        n_checks++;
        if ({ifc.alu_lt, ifc.alu_ltu} !== 2'b10) begin
            n_fail++;
            $display("FAIL flags_lt: got %b%b want 10", ifc.alu_lt, ifc.alu_ltu);
        end
        for (int i = 0; i < 4; i++) begin
            exec(ops[i]);
            read_bus(v);
            n_checks++;
            if (v !== exp[i]) begin
                n_fail++;
                $display("FAIL shift_op%0d: got %h want %h", ops[i], v, exp[i]);
            end
        end
        exec(SLTU);
        read_bus(v);
        n_checks++;
        if (v !== 32'd0) begin
            n_fail++;
            $display("FAIL sltu: got %h want 00000000", v);
        end
    endtask

    task automatic test_logic();
        logic [4:0]  ops [6] = '{XORO, ORO, ANDO, PASSB, 5'd19, 5'd31};
        logic [31:0] exp [6] = '{32'hFF00_0FF0, 32'hFFF0_0FFF, 32'h00F0_000F,
                                 32'h0FF0_0F0F, 32'd0, 32'd0};
        logic [31:0] v;
        load_a(32'hF0F0_00FF);
        load_b(32'h0FF0_0F0F);
        for (int i = 0; i < 6; i++) begin
            exec(ops[i]);
            read_bus(v);
            n_checks++;
            if (v !== exp[i]) begin
                n_fail++;
                $display("FAIL logic_op%0d: got %h want %h", ops[i], v, exp[i]);
            end
        end
    endtask

    task automatic test_mul();
        logic [4:0]  ops [4] = '{MUL, MULH, MULHU, MULHSU};
        logic [31:0] exp [4] = '{32'd1, 32'd0, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
        logic [31:0] v;
        load_a(32'hFFFF_FFFF);
        load_b(32'hFFFF_FFFF);
        for (int i = 0; i < 4; i++) begin
            exec(ops[i]);
            read_bus(v);
            n_checks++;
            if (v !== exp[i]) begin
                n_fail++;
                $display("FAIL mul_op%0d: got %h want %h", ops[i], v, exp[i]);
            end
        end
        load_a(32'h1234_5678);
        load_b(32'h0000_0010);
        exec(MUL);
        read_bus(v);
        n_checks++;
        if (v !== 32'h2345_6780) begin
            n_fail++;
            $display("FAIL mul_small: got %h want 23456780", v);
        end
        exec(MULHU);
        read_bus(v);
        n_checks++;
        if (v !== 32'h0000_0001) begin
            n_fail++;
            $display("FAIL mulhu_small: got %h want 00000001", v);
        end
    endtask

    task automatic test_div();
        logic [31:0] av  [3] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFF9};
        logic [31:0] bv  [3] = '{32'd0, 32'hFFFF_FFFF, 32'd2};
        logic [4:0]  ops [4] = '{DIV, DIVU, REM, REMU};
        logic [31:0] exp [12] = '{
            32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd7, 32'd7,
            32'h8000_0000, 32'd0, 32'd0, 32'h8000_0000,
            32'hFFFF_FFFD, 32'h7FFF_FFFC, 32'hFFFF_FFFF, 32'd1};
        logic [31:0] v;
        for (int i = 0; i < 3; i++) begin
            load_a(av[i]);
            load_b(bv[i]);
            for (int j = 0; j < 4; j++) begin
                exec(ops[j]);
                read_bus(v);
                n_checks++;
                if (v !== exp[i*4+j]) begin
                    n_fail++;
                    $display("FAIL div_v%0d_op%0d: got %h want %h",
                             i, ops[j], v, exp[i*4+j]);
                end
            end
        end
    endtask

    task automatic test_bus();
        logic [31:0] v;
        load_a(32'd0);
        load_b(32'd1);
        exec(SUB);
        ifc.alu_out_en = 1'b0;
        drv = PAT;
        drv_en = 1'b1;
        #1;
        n_checks++;
        if (bus !== PAT) begin
            n_fail++;
            $display("FAIL bus_hiz: got %h want %h", bus, PAT);
        end
        drv_en = 1'b0;
        ifc.alu_out_en = 1'b1;
        ifc.alu_a_load = 1'b1;
        cycle();
        idle();
        load_b(32'd2);
        exec(ADD);
        read_bus(v);
        n_checks++;
        if (v !== 32'd1) begin
            n_fail++;
            $display("FAIL bus_forward: got %h want 00000001", v);
        end
        load_a(32'd10);
        load_b(32'd3);
        drv = 32'd5;
        drv_en = 1'b1;
        ifc.alu_b_load = 1'b1;
        ifc.alu_op = SUB;
        ifc.alu_execute = 1'b1;
        cycle();
        idle();
        read_bus(v);
        n_checks++;
        if (v !== 32'd7) begin
            n_fail++;
            $display("FAIL exec_old_b: got %h want 00000007", v);
        end
        cycle();
        cycle();
        read_bus(v);
        n_checks++;
        if (v !== 32'd7) begin
            n_fail++;
            $display("FAIL idle_hold: got %h want 00000007", v);
        end
        exec(SUB);
        read_bus(v);
        n_checks++;
        if (v !== 32'd5) begin
            n_fail++;
            $display("FAIL exec_new_b: got %h want 00000005", v);
        end
    endtask

    initial begin
        idle();
        reset = 1'b1;
        cycle();
        cycle();
        reset = 1'b0;
        test_reset();
        test_add_sub();
        test_shift_cmp();
        test_logic();
        test_mul();
        test_div();
        test_bus();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/alu.md
# alu

Combinational-plus-registered RV32IM arithmetic logic unit on the CPU's shared 32-bit tri-state data bus. The control unit sequences it: operands are latched from the bus, an operation is executed into a result register, and the result is driven back onto the bus on request. It covers every RV32I ALU operation plus the full M extension, with RISC-V divide-by-zero and overflow semantics.

## Interface
- No parameters; data width fixed at 32.
- `clock` in 1: single system clock, all state on rising edge.
- `reset` in 1: synchronous, active-high; clears all registers.
- `bus` inout 32: shared tri-state data bus; read for operands, driven with the result.
- `alu_a_load` in 1: latch `bus` into operand A.
- `alu_b_load` in 1: latch `bus` into operand B.
- `alu_op` in 5: operation select, encoding below.
- `alu_execute` in 1: capture the selected operation's result into R.
- `alu_out_en` in 1: drive R onto `bus`; otherwise `bus` is high-Z.
- `alu_zero` out 1: R == 0.
- `alu_lt` out 1: signed A < B, combinational from A and B, for branches.
- `alu_ltu` out 1: unsigned A < B, combinational from A and B.

## Operation
- `alu_op` encoding:
  - 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND.
  - 10 MUL, 11 MULH, 12 MULHSU, 13 MULHU, 14 DIV, 15 DIVU, 16 REM, 17 REMU.
  - 18 PASS_B (R = B); codes 19–31 yield 0.
- Arithmetic wraps modulo 2^32.
- Shifts use B[4:0] only.
- SLT and SLTU produce 0 or 1.
- MUL returns the low 32 bits of the product.
- MULH, MULHSU and MULHU return the high 32 bits of the 64-bit signed×signed, signed A × unsigned B, and unsigned×unsigned products respectively.
- Divide by zero: DIV and DIVU give 0xFFFFFFFF; REM and REMU give A.
- Signed overflow (A = 0x80000000, B = 0xFFFFFFFF): DIV gives 0x80000000; REM gives 0.
- Signed division truncates toward zero; the remainder takes the sign of the dividend.
- Division and multiplication are combinational, single cycle, with no busy handshake.
- Bus driving: `bus` = R while `alu_out_en` = 1, else 'z. During reset, `bus` is released regardless of `alu_out_en`.

## Timing
- Reset values: A = 0, B = 0, R = 0, `alu_zero` = 1, `alu_lt` = 0, `alu_ltu` = 0, `bus` high-Z.
- Reset has priority over loads and execute in the same cycle.
- Load: when `alu_a_load` or `alu_b_load` is high at a rising edge, the bus value is captured and visible the next cycle. Both may assert together and capture the same value.
- Execute: when `alu_execute` is high at a rising edge, R takes op(A, B) using A and B as they were before that edge. An operand load in the same cycle does not affect that result.
- End-to-end latency: load A (cycle 1), load B (cycle 2), execute (cycle 3), result on bus (cycle 4). Execute may coincide with the second load only if the result is intended to use the old operand.
- Out-to-load: with `alu_out_en` and `alu_a_load` both high, A captures the old R (forwarding path). The ALU does not detect external bus contention.
- Idle: R, A and B hold when their controls are low.
- Output timing: `alu_zero` is registered-derived from R. `alu_lt`/`alu_ltu` track A and B the cycle after a load.

## Test plan
- Reset: assert `reset` for 2 cycles with all controls high → A = B = R = 0, `bus` high-Z, `alu_zero` = 1.
- ADD/SUB wrap: A = 0xFFFFFFFF, B = 1, ADD → bus 0x00000000 and `alu_zero` = 1. SUB with A = 0, B = 1 → 0xFFFFFFFF.
- Shifts and compares:
  - A = 0x80000000, B = 0x21: SRA → 0xC0000000 (shamt 1), SRL → 0x40000000.
  - SLT → 1 and SLTU → 0, with `alu_lt` = 1 and `alu_ltu` = 0.
- Multiply: A = 0xFFFFFFFF, B = 0xFFFFFFFF → MUL 0x00000001, MULH 0x00000000, MULHU 0xFFFFFFFE, MULHSU 0xFFFFFFFF.
- Divide corners:
  - A = 7, B = 0: DIV → 0xFFFFFFFF, REM → 7.
  - A = 0x80000000, B = 0xFFFFFFFF: DIV → 0x80000000, REM → 0.
  - A = −7, B = 2: DIV → −3, REM → −1.
- Bus protocol: `alu_out_en` = 0 → bus reads 'z. `alu_out_en` = 1 together with `alu_a_load` → A equals the prior R. Execute in the same cycle as `alu_b_load` → result uses the old B.
